// File: rtl/v810_dataram_pkg.sv
// v810_dataram_pkg
// Shared definitions for the byte-enabled data RAM slice:
//   - LANE_WIDTH : width of one byte lane (the RAM is built from lanes of this width)
//   - state_t    : controller states (SWEEP zeroes the array, IDLE serves reads/writes)
package v810_dataram_pkg;

  localparam int LANE_WIDTH = 8;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/v810_dataram_lane.sv
// v810_dataram_lane
// One byte lane of the data RAM: simple dual-port storage with a registered read.
// Ports:
//   clock      : rising-edge clock
//   reset_n    : async active-low reset, clears only the read register (never the array)
//   wr_en      : write this lane's byte at wr_address
//   wr_address : write address
//   wr_data    : byte to write
//   rd_en      : capture the addressed byte into rd_data
//   rd_address : read address
//   rd_data    : registered read byte, holds while rd_en=0
module v810_dataram_lane
  import v810_dataram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [LANE_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [LANE_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [LANE_WIDTH-1:0] mem [DEPTH];
  logic                  forward;

  // Storage has no reset; it is zeroed only by the controller's sweep.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_address] <= wr_data;
    end
  end

  // A same-cycle write to the address being read is forwarded when bypass is on;
  // otherwise the array read returns the pre-write byte.
  assign forward = (BYPASS != 0) && wr_en && (wr_address == rd_address);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= forward ? wr_data : mem[rd_address];
    end
  end

endmodule

// File: rtl/v810_dataram_be.sv
// v810_dataram_be
// Byte-enabled simple dual-port data RAM with a zeroing sweep after reset or on request.
// Ports:
//   clock      : rising-edge clock
//   reset_n    : async active-low reset; restarts the zeroing sweep from address 0
//   clear_req  : request a full-array zero sweep (honoured only when idle)
//   busy       : high while reset or a sweep is active; reads/writes ignored then
//   rd_en      : read request
//   rd_address : read address
//   rd_data    : read data, held while rd_valid=0
//   rd_valid   : rd_data carries an accepted read, RD_LATENCY cycles after acceptance
//   wr_en      : write request
//   wr_be      : per-byte write enables, bit i covers bits [8i+7:8i]
//   wr_address : write address
//   wr_data    : write data
module v810_dataram_be
  import v810_dataram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             clear_req,
  output logic                             busy,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_address,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  input  logic                             wr_en,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]            wr_address,
  input  logic [DATA_WIDTH-1:0]            wr_data
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("v810_dataram_be: RD_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_width
      $error("v810_dataram_be: DATA_WIDTH must be a multiple of 8");
    end
  endgenerate

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH:0]   sweep_ptr;
  logic [ADDR_WIDTH:0]   sweep_ptr_next;
  logic [ADDR_WIDTH:0]   sweep_ptr_inc;
  logic                  sweeping;
  logic                  rd_accept;
  logic                  wr_accept;
  logic [ADDR_WIDTH-1:0] lane_wr_address;
  logic [DATA_WIDTH-1:0] lane_wr_data;
  logic [LANES-1:0]      lane_wr_en;
  logic [DATA_WIDTH-1:0] lane_rd_data;
  logic                  valid_s1;

  // Controller state register. Reset lands in SWEEP at address 0 so that
  // releasing reset always zeroes the whole array before service begins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SWEEP;
      sweep_ptr <= '0;
    end else begin
      state     <= state_next;
      sweep_ptr <= sweep_ptr_next;
    end
  end

  // The pointer carries one extra bit so the step past the last address shows
  // up in the MSB; that is the termination condition.
  assign sweep_ptr_inc = sweep_ptr + {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Next-state logic. clear_req is only looked at in IDLE.
  always_comb begin
    state_next     = state;
    sweep_ptr_next = sweep_ptr;
    sweeping       = 1'b0;
    case (state)
      SWEEP: begin
        sweeping       = 1'b1;
        sweep_ptr_next = sweep_ptr_inc;
        if (sweep_ptr_inc[ADDR_WIDTH]) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_next     = SWEEP;
          sweep_ptr_next = '0;
        end
      end
    endcase
  end

  assign busy      = sweeping;
  assign rd_accept = rd_en & ~sweeping;
  assign wr_accept = wr_en & ~sweeping;

  // While sweeping, the write port is taken over to write zero at the pointer.
  assign lane_wr_address = sweeping ? sweep_ptr[ADDR_WIDTH-1:0] : wr_address;
  assign lane_wr_data    = sweeping ? '0 : wr_data;
  assign lane_wr_en      = sweeping ? {LANES{1'b1}} : ({LANES{wr_accept}} & wr_be);

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      v810_dataram_lane #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYPASS     (BYPASS)
      ) u_lane (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (lane_wr_en[i]),
        .wr_address (lane_wr_address),
        .wr_data    (lane_wr_data[i*LANE_WIDTH +: LANE_WIDTH]),
        .rd_en      (rd_accept),
        .rd_address (rd_address),
        .rd_data    (lane_rd_data[i*LANE_WIDTH +: LANE_WIDTH])
      );
    end
  endgenerate

  // First read-pipeline valid bit, aligned with the lanes' registered read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_s1 <= 1'b0;
    end else begin
      valid_s1 <= rd_accept;
    end
  end

  // With two-cycle latency an extra output stage follows the lanes. It keeps
  // advancing during a sweep, so reads already in flight finish with the data
  // captured before the sweep began.
  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  valid_s2;
      logic [DATA_WIDTH-1:0] data_s2;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          valid_s2 <= 1'b0;
          data_s2  <= '0;
        end else begin
          valid_s2 <= valid_s1;
          if (valid_s1) begin
            data_s2 <= lane_rd_data;
          end
        end
      end

      assign rd_valid = valid_s2;
      assign rd_data  = data_s2;
    end else begin : g_lat1
      assign rd_valid = valid_s1;
      assign rd_data  = lane_rd_data;
    end
  endgenerate

endmodule
